// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types for the fifo write arbiter
package fifo_arb_pkg;
   localparam int DATA_W = 8;
   typedef enum logic {IDLE, BURST} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder: first request at or after ptr, modulo NUM_REQ
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);
   logic found;
   int   j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin write-port arbiter with burst lock and credit tracking
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ENTRIES   = 4,
   parameter int BURST_MAX = 2,
   localparam int IDX_W    = $clog2(NUM_REQ),
   localparam int CRED_W   = $clog2(ENTRIES) + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               in_req_valid,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   in_req_data,
   output logic [NUM_REQ-1:0]               out_req_ready,
   input  logic                             in_fifo_read,
   output logic                             out_fifo_write,
   output logic [DATA_W-1:0]                out_fifo_data,
   output logic [IDX_W-1:0]                 out_grant_id,
   output logic [CRED_W-1:0]                out_credits,
   output logic                             out_busy
);
   localparam int BEAT_W = $clog2(BURST_MAX + 1);

   arb_state_t          state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    owner;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [NUM_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic [NUM_REQ-1:0]  owner_mask;
   logic [IDX_W-1:0]    acc_idx;
   logic                accept;
   logic                pop_eff;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
      return IDX_W'((int'(i) + 1) % NUM_REQ);
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req   (in_req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   assign owner_mask = NUM_REQ'(1) << owner;
   assign acc_idx    = (state == IDLE) ? pick_idx : owner;
   assign accept     = |(in_req_valid & out_req_ready);
   // A pop with every slot already free cannot correspond to a real entry.
   assign pop_eff    = in_fifo_read && (out_credits != CRED_W'(ENTRIES));

   always_comb begin
      out_req_ready = '0;
      if (out_credits != '0)
         out_req_ready = (state == IDLE) ? pick_grant : owner_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         owner          <= '0;
         beat_cnt       <= '0;
         out_credits    <= CRED_W'(ENTRIES);
         out_fifo_write <= 1'b0;
         out_fifo_data  <= '0;
         out_grant_id   <= '0;
         out_busy       <= 1'b0;
      end else begin
         out_fifo_write <= accept;
         if (accept) begin
            out_fifo_data <= in_req_data[acc_idx];
            out_grant_id  <= acc_idx;
         end

         case ({accept, pop_eff})
            2'b10:   out_credits <= out_credits - CRED_W'(1);
            2'b01:   out_credits <= out_credits + CRED_W'(1);
            default: out_credits <= out_credits;
         endcase

         case (state)
            IDLE: begin
               if (accept) begin
                  if (BURST_MAX == 1) begin
                     rr_ptr <= next_ptr(pick_idx);
                  end else begin
                     owner    <= pick_idx;
                     beat_cnt <= BEAT_W'(1);
                     state    <= BURST;
                     out_busy <= 1'b1;
                  end
               end
            end
            BURST: begin
               // Owner dropping valid releases the lock; that cycle grants nobody.
               if (!in_req_valid[owner]) begin
                  state    <= IDLE;
                  rr_ptr   <= next_ptr(owner);
                  out_busy <= 1'b0;
               end else if (accept) begin
                  if ((int'(beat_cnt) + 1) == BURST_MAX) begin
                     state    <= IDLE;
                     rr_ptr   <= next_ptr(owner);
                     out_busy <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               out_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
